// File: rtl/sim_run_monitor_if.sv
// Harness-side bus of the run monitor: instruction tap, register-file read port,
// dump stream and run status.
interface sim_run_monitor_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CNT_W     = 32
);
    logic [DATA_W-1:0]    ip_instr;
    logic                 ip_instr_valid;
    logic [REG_IDX_W-1:0] op_rf_raddr;
    logic [DATA_W-1:0]    ip_rf_rdata;
    logic                 op_dump_valid;
    logic                 ip_dump_ready;
    logic [REG_IDX_W-1:0] op_dump_idx;
    logic [DATA_W-1:0]    op_dump_data;
    logic [CNT_W-1:0]     op_cycle_count;
    logic [CNT_W-1:0]     op_halt_cycle;
    logic                 op_done;
    logic                 op_timeout;

    modport master (
        input  ip_instr, ip_instr_valid, ip_rf_rdata, ip_dump_ready,
        output op_rf_raddr, op_dump_valid, op_dump_idx, op_dump_data,
               op_cycle_count, op_halt_cycle, op_done, op_timeout
    );

    modport slave (
        output ip_instr, ip_instr_valid, ip_rf_rdata, ip_dump_ready,
        input  op_rf_raddr, op_dump_valid, op_dump_idx, op_dump_data,
               op_cycle_count, op_halt_cycle, op_done, op_timeout
    );
endinterface

// File: rtl/sim_run_monitor.sv
// Run control for processor test harnesses: cycle count, halt detection,
// pipeline drain, timeout and a valid/ready register-file dump.
module sim_run_monitor #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned REG_IDX_W      = 5,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DRAIN_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
    input  logic clk,
    input  logic rst,
    sim_run_monitor_if.master bus
);
    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]        DRAIN_LAST = DW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]     TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REG_IDX_W-1:0] IDX_LAST   = REG_IDX_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {S_RUN, S_DRAIN, S_DUMP, S_DONE, S_TIMEOUT} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     halt_q, halt_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [REG_IDX_W-1:0] idx_q, idx_d;
    logic                 halt_det;
    logic [CNT_W-1:0]     cnt_inc;

    assign halt_det = bus.ip_instr_valid && (bus.ip_instr == HALT_WORD);
    // Saturating increment: a stuck counter is easier to spot than a wrapped one.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        drain_d = drain_q;
        idx_d   = idx_q;
        case (state_q)
            S_RUN: begin
                cnt_d = cnt_inc;
                // Halt is checked first so it wins over a same-cycle timeout.
                if (halt_det) begin
                    halt_d  = cnt_q;
                    drain_d = '0;
                    idx_d   = '0;
                    state_d = (DRAIN_CYCLES == 0) ? S_DUMP : S_DRAIN;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_TIMEOUT;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_inc;
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DUMP;
                    idx_d   = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DUMP: begin
                if (bus.ip_dump_ready) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            halt_q  <= '0;
            drain_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            drain_q <= drain_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.op_dump_valid  = (state_q == S_DUMP);
    assign bus.op_rf_raddr    = (state_q == S_DUMP) ? idx_q : '0;
    assign bus.op_dump_idx    = idx_q;
    assign bus.op_dump_data   = bus.ip_rf_rdata;
    assign bus.op_cycle_count = cnt_q;
    assign bus.op_halt_cycle  = halt_q;
    assign bus.op_done        = (state_q == S_DONE);
    assign bus.op_timeout     = (state_q == S_TIMEOUT);
endmodule

// File: doc/sim_run_monitor.md
# sim_run_monitor

Synthesizable run-control and result-capture block for processor test harnesses. Watches the fetched instruction stream, counts cycles from reset release, detects the halt word, waits a configurable number of pipeline-drain cycles, then streams every register-file entry out over a valid/ready interface. Replaces ad-hoc bench-side halt detection, cycle counting, timeout and register dumping with one parametrised block. Sits beside the processor, tapping the imem output and a spare register-file read port.

## Interface
- DATA_W, 32, instruction and register data width
- NUM_REGS, 32, register-file entries to dump (>=1)
- REG_IDX_W, 5, register index width (2^REG_IDX_W >= NUM_REGS)
- CNT_W, 32, cycle-counter width
- DRAIN_CYCLES, 5, cycles waited after halt before dumping (0 allowed)
- TIMEOUT_CYCLES, 100, RUN-state cycle limit (>=1)
- HALT_WORD, 0, instruction value marking end of program

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ip_instr  in  DATA_W  instruction from imem
- ip_instr_valid  in  1  ip_instr is valid this cycle
- op_rf_raddr  out  REG_IDX_W  register-file read address
- ip_rf_rdata  in  DATA_W  asynchronous read data for op_rf_raddr
- op_dump_valid  out  1  dump beat valid
- ip_dump_ready  in  1  consumer accepts beat
- op_dump_idx  out  REG_IDX_W  register index of current beat
- op_dump_data  out  DATA_W  register value of current beat
- op_cycle_count  out  CNT_W  running cycle count
- op_halt_cycle  out  CNT_W  op_cycle_count value when halt was detected
- op_done  out  1  dump complete (sticky)
- op_timeout  out  1  timeout occurred (sticky)

## Operation
- States: RUN, DRAIN, DUMP, DONE, TIMEOUT. Reset state RUN.
- Halt detect: ip_instr_valid=1 and ip_instr==HALT_WORD. ip_instr==HALT_WORD with valid=0 is ignored.
- RUN: cycle counter increments each cycle. On halt detect: op_halt_cycle <= op_cycle_count (pre-increment value); go DRAIN (or DUMP if DRAIN_CYCLES==0), drain counter cleared. Else if op_cycle_count==TIMEOUT_CYCLES-1: go TIMEOUT. Halt and timeout in same cycle: halt wins.
- DRAIN: cycle counter keeps incrementing; drain counter increments; after DRAIN_CYCLES cycles in DRAIN go DUMP with index 0. Halt words ignored.
- DUMP: cycle counter frozen. op_rf_raddr=op_dump_idx=index; op_dump_data=ip_rf_rdata (combinational); op_dump_valid=1. Transfer when valid&&ready: index+1; transfer at index NUM_REGS-1 goes DONE. Without ready, index and outputs hold.
- DONE: op_done=1, op_dump_valid=0, counters frozen, until rst.
- TIMEOUT: op_timeout=1, counter frozen, no dump ever issued, until rst.
- Cycle counter saturates at 2^CNT_W-1; never wraps.
- op_rf_raddr=0 outside DUMP.

## Timing
- Reset (rst high at a rising edge): state RUN, op_cycle_count=0, op_halt_cycle=0, op_done=0, op_timeout=0, op_dump_valid=0, op_dump_idx=0, op_rf_raddr=0 after that edge.
- Reset mid-operation (any state, incl. DUMP with stalled beat): same values next cycle; partial dump abandoned.
- After rst released, op_cycle_count = number of rising edges elapsed in RUN/DRAIN.
- Halt sampled at edge N (count=N beforehand): op_halt_cycle=N; first op_dump_valid exactly DRAIN_CYCLES+1 edges later.
- Timeout: op_timeout rises at edge where count reaches TIMEOUT_CYCLES; op_cycle_count then = TIMEOUT_CYCLES.
- Dump throughput: one beat per cycle with ready held high; NUM_REGS beats; op_done rises the edge after last transfer.

## Test plan
- 7 valid nonzero instrs after reset release, then 0 with valid=1; rf[i]=i*0x11, ready=1 -> op_halt_cycle=7, op_dump_valid first high 6 edges later, 32 beats idx 0..31 data i*0x11, op_done=1, op_timeout=0.
- Same run with ready toggling 1,0,1,0 -> each idx exactly once in order, idx/data stable during stalls, op_done after 32 transfers.
- Never halt, TIMEOUT_CYCLES=100 -> op_timeout=1 with op_cycle_count=100, op_dump_valid never high, op_done=0.
- HALT_WORD on ip_instr with valid=0 at cycles 3..10, valid halt at edge 99 -> no early halt; halt wins over timeout, op_halt_cycle=99, op_timeout=0.
- DRAIN_CYCLES=0 -> op_dump_valid high the cycle after halt edge.
- rst asserted for one edge during beat idx=12 with ready=0 -> all outputs reset values next cycle; fresh run yields full 0..31 dump.
